pid_pwm_out: RTL and testbench

Downstream output stage of the velocity loop: it consumes the 32-bit signed controller output `un` with its `valid` strobe and converts it into a motor drive signal. It scales the value, takes its magnitude, saturates it and double-buffers it. It then drives a PWM output plus a direction line, with dead time inserted on every direction reversal. It sits between the PID block and the H-bridge pins.

---
 rtl/pid_pkg.sv | 17 +
 rtl/un_to_duty.sv | 30 +++
 rtl/pid_pwm_out.sv | 139 +++++++++++++
 tb/tb_pid_pwm_out.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the velocity-loop PID and its PWM output stage.
package pid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } pwm_state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int PWM_BITS_DEF    = 10;
  localparam int UN_SHIFT_DEF    = 8;
  localparam int DEAD_CYCLES_DEF = 16;

endpackage

// File: rtl/un_to_duty.sv
// Combinational datapath: signed controller output -> direction, saturated duty, sat flag.
module un_to_duty
  import pid_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int UN_SHIFT = UN_SHIFT_DEF
) (
  input  logic [31:0]         i_un,
  output logic                o_dir,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_sat
);

  localparam logic [32:0] MAX_MAG = 33'((1 << PWM_BITS) - 1);

  logic [32:0] un_ext;
  logic [32:0] abs_un;
  logic [32:0] mag;

  // 33-bit negate so that -2^31 has a representable magnitude
  always_comb begin
    un_ext = {i_un[31], i_un};
    abs_un = un_ext[32] ? (~un_ext + 33'd1) : un_ext;
    mag    = abs_un >> UN_SHIFT;
    o_sat  = (mag > MAX_MAG);
    o_duty = o_sat ? {PWM_BITS{1'b1}} : mag[PWM_BITS-1:0];
    o_dir  = un_ext[32] ? DIR_REV : DIR_FWD;
  end

endmodule

// File: rtl/pid_pwm_out.sv
// PWM output stage: shadow/active duty buffering, period counter and dead-time FSM.
//   state | meaning
//   IDLE  | disabled or in reset; counter held at 0, drive off
//   RUN   | driving o_pwm with the active duty
//   DEAD  | forced off while o_dir switches to the new direction
module pid_pwm_out
  import pid_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int UN_SHIFT    = UN_SHIFT_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [31:0]         i_un,
  input  logic                i_valid,
  input  logic                i_enable,
  output logic                o_pwm,
  output logic                o_dir,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_sat,
  output logic                o_period_start
);

  localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] DEAD_LOAD = PWM_BITS'(DEAD_CYCLES);
  localparam logic [PWM_BITS-1:0] DEAD_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  pwm_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] dead_q, dead_d;
  logic [PWM_BITS-1:0] shadow_duty_q, shadow_duty_d;
  logic                shadow_dir_q, shadow_dir_d;
  logic                dir_q, dir_d;
  logic                sat_q, sat_d;
  logic                pwm_q, pwm_d;
  logic                ps_q, ps_d;

  logic                cap_dir;
  logic [PWM_BITS-1:0] cap_duty;
  logic                cap_sat;

  un_to_duty #(
    .PWM_BITS (PWM_BITS),
    .UN_SHIFT (UN_SHIFT)
  ) u_un_to_duty (
    .i_un   (i_un),
    .o_dir  (cap_dir),
    .o_duty (cap_duty),
    .o_sat  (cap_sat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      duty_q        <= '0;
      dead_q        <= '0;
      shadow_duty_q <= '0;
      shadow_dir_q  <= DIR_FWD;
      dir_q         <= DIR_FWD;
      sat_q         <= 1'b0;
      pwm_q         <= 1'b0;
      ps_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      dead_q        <= dead_d;
      shadow_duty_q <= shadow_duty_d;
      shadow_dir_q  <= shadow_dir_d;
      dir_q         <= dir_d;
      sat_q         <= sat_d;
      pwm_q         <= pwm_d;
      ps_q          <= ps_d;
    end
  end

  // All outputs are registered, so decisions are made for the cycle being entered.
  always_comb begin
    shadow_dir_d  = shadow_dir_q;
    shadow_duty_d = shadow_duty_q;
    sat_d         = sat_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    dead_d        = dead_q;
    dir_d         = dir_q;
    ps_d          = 1'b0;

    if (i_valid) begin
      shadow_dir_d  = cap_dir;
      shadow_duty_d = cap_duty;
      sat_d         = cap_sat;
    end

    if (state_q == DEAD && dead_q != '0) begin
      dead_d = dead_q - 1'b1;
      if (dead_q == DEAD_ONE) dir_d = shadow_dir_q;
    end

    if (!i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      duty_d  = '0;
      dead_d  = '0;
      dir_d   = dir_q;
    end else begin
      if (state_q == IDLE || cnt_q == CNT_LAST) begin
        cnt_d = '0;
        ps_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Period start uses the shadow as it stands after this cycle's capture.
      if (ps_d) begin
        if (shadow_dir_d == dir_d) begin
          state_d = RUN;
          duty_d  = shadow_duty_d;
        end else begin
          state_d = DEAD;
          duty_d  = '0;
          dead_d  = DEAD_LOAD;
        end
      end
    end

    pwm_d = (state_d == RUN) && (cnt_d < duty_d);
  end

  assign o_pwm          = pwm_q;
  assign o_dir          = dir_q;
  assign o_duty         = duty_q;
  assign o_sat          = sat_q;
  assign o_period_start = ps_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed bench for pid_pwm_out with PWM_BITS=4, UN_SHIFT=4, DEAD_CYCLES=3.
module tb_pid_pwm_out;

  localparam int PB  = 4;
  localparam int PER = 15;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [31:0]   i_un;
  logic          i_valid;
  logic          i_enable;
  logic          o_pwm;
  logic          o_dir;
  logic [PB-1:0] o_duty;
  logic          o_sat;
  logic          o_period_start;

  int n_chk = 0;
  int n_err = 0;

  pid_pwm_out #(
    .PWM_BITS    (PB),
    .UN_SHIFT    (4),
    .DEAD_CYCLES (3)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_un           (i_un),
    .i_valid        (i_valid),
    .i_enable       (i_enable),
    .o_pwm          (o_pwm),
    .o_dir          (o_dir),
    .o_duty         (o_duty),
    .o_sat          (o_sat),
    .o_period_start (o_period_start)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Starts on a period-start cycle, checks every cycle of one period, optionally strobes i_un.
  task automatic run_period(input string tag, input int duty,
                            input logic dir_pre, input logic dir_post, input int dir_at,
                            input int stb_at, input logic [31:0] stb_un,
                            input logic sat_pre, input logic sat_post);
    for (int k = 0; k < PER; k++) begin
      check($sformatf("%s ps k%0d", tag, k),   32'(o_period_start), 32'(k == 0));
      check($sformatf("%s pwm k%0d", tag, k),  32'(o_pwm),          32'(k < duty));
      check($sformatf("%s duty k%0d", tag, k), 32'(o_duty),         32'(duty));
      check($sformatf("%s dir k%0d", tag, k),  32'(o_dir),          32'((k < dir_at) ? dir_pre : dir_post));
      check($sformatf("%s sat k%0d", tag, k),  32'(o_sat),          32'((k <= stb_at) ? sat_pre : sat_post));
      i_valid = (k == stb_at);
      i_un    = (k == stb_at) ? stb_un : 32'h0;
      tick();
      i_valid = 1'b0;
    end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_enable = 1'b1;
    i_un     = 32'h0;
    repeat (3) tick();
    check("rst pwm",  32'(o_pwm),          32'h0);
    check("rst dir",  32'(o_dir),          32'h0);
    check("rst duty", 32'(o_duty),         32'h0);
    check("rst sat",  32'(o_sat),          32'h0);
    check("rst ps",   32'(o_period_start), 32'h0);

    i_rst = 1'b0;
    tick();
    run_period("p0",      0,  1'b0, 1'b0, 99, 7,  32'h0000_0050, 1'b0, 1'b0);
    run_period("t2a",     5,  1'b0, 1'b0, 99, 99, 32'h0,         1'b0, 1'b0);
    run_period("t2b",     5,  1'b0, 1'b0, 99, 14, 32'h0000_0020, 1'b0, 1'b0);
    run_period("t5a",     2,  1'b0, 1'b0, 99, 0,  32'h0000_0090, 1'b0, 1'b0);
    run_period("t5b",     9,  1'b0, 1'b0, 99, 5,  32'h0000_0050, 1'b0, 1'b0);
    run_period("t4a",     5,  1'b0, 1'b0, 99, 3,  32'hFFFF_FFD0, 1'b0, 1'b0);
    run_period("t4dead",  0,  1'b0, 1'b1, 3,  99, 32'h0,         1'b0, 1'b0);
    run_period("t4b",     3,  1'b1, 1'b1, 99, 6,  32'h7FFF_FFFF, 1'b0, 1'b1);
    run_period("t3dead",  0,  1'b1, 1'b0, 3,  99, 32'h0,         1'b1, 1'b1);
    run_period("t3a",     15, 1'b0, 1'b0, 99, 2,  32'h8000_0000, 1'b1, 1'b1);
    run_period("t3dead2", 0,  1'b0, 1'b1, 3,  99, 32'h0,         1'b1, 1'b1);
    run_period("t3b",     15, 1'b1, 1'b1, 99, 99, 32'h0,         1'b1, 1'b1);

    repeat (4) tick();
    check("t6 pwm before", 32'(o_pwm), 32'h1);
    i_enable = 1'b0;
    tick();
    check("t6 off pwm",   32'(o_pwm),          32'h0);
    check("t6 off duty",  32'(o_duty),         32'h0);
    check("t6 off ps",    32'(o_period_start), 32'h0);
    check("t6 off dir",   32'(o_dir),          32'h1);
    check("t6 off sat",   32'(o_sat),          32'h1);
    check("t6 off cnt",   32'(dut.cnt_q),      32'h0);
    check("t6 off state", 32'(dut.state_q),    32'(pid_pkg::IDLE));
    tick();
    check("t6 off2 pwm", 32'(o_pwm),     32'h0);
    check("t6 off2 cnt", 32'(dut.cnt_q), 32'h0);
    i_enable = 1'b1;
    tick();
    run_period("t6re", 15, 1'b1, 1'b1, 99, 0, 32'h0000_0050, 1'b1, 1'b0);

    check("t6 dead ps",   32'(o_period_start), 32'h1);
    check("t6 dead duty", 32'(o_duty),         32'h0);
    check("t6 dead pwm",  32'(o_pwm),          32'h0);
    check("t6 dead dir",  32'(o_dir),          32'h1);
    check("t6 dead st",   32'(dut.state_q),    32'(pid_pkg::DEAD));
    tick();
    i_rst = 1'b1;
    tick();
    check("t6 rst pwm",   32'(o_pwm),          32'h0);
    check("t6 rst dir",   32'(o_dir),          32'h0);
    check("t6 rst duty",  32'(o_duty),         32'h0);
    check("t6 rst sat",   32'(o_sat),          32'h0);
    check("t6 rst ps",    32'(o_period_start), 32'h0);
    check("t6 rst state", 32'(dut.state_q),    32'(pid_pkg::IDLE));
    check("t6 rst cnt",   32'(dut.cnt_q),      32'h0);
    i_rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
